a2d_rr_sched: RTL and testbench
===============================

// Module: a2d_rr_sched
// PURPOSE
//  Round-robin scheduler sharing the single 16-bit SPI master (to the A2D) among the four analog
//  readings the segway needs: lft_ld, rght_ld, steer_pot, batt. Each period it issues one
//  conversion per channel and holds the registered 12-bit results for steer_en, balance and
//  battery logic. Sits between the SPI master and all consumers of load-cell/pot/battery data.
// PARAMETERS
//  fast_sim  1'b1  1: round period 2^10 clks (simulation); 0: 2^18 clks (~5.24 ms @ 50 MHz)
// PORTS
//  clk        in   1   50 MHz system clock
//  rst        in   1   synchronous, active-high reset
//  nxt        in   1   one-cycle request to start a round immediately (ORed with period timer)
//  wrt        out  1   one-cycle strobe to SPI master: start 16-bit transaction
//  cmd        out  16  SPI command word, valid when wrt=1
//  done       in   1   one-cycle pulse from SPI master: transaction complete
//  rd_data    in   16  SPI return word, valid on done
//  lft_ld     out  12  left load cell result   (A2D ch0)
//  rght_ld    out  12  right load cell result  (A2D ch4)
//  steer_pot  out  12  steering pot result     (A2D ch5)
//  batt       out  12  battery voltage result  (A2D ch6)
//  vld        out  1   one-cycle pulse: all four results updated this round
//  busy       out  1   high from round start until cycle after last result stored
// BEHAVIOUR
//  - Reset: all outputs 0 (results 12'h000, wrt=0, cmd=16'h0000, vld=0, busy=0); FSM->IDLE;
//    period timer and pending flag cleared. Reset mid-transaction aborts; no partial write.
//  - Round start: pending flag set by nxt or timer terminal count; IDLE with pending -> CMD,
//    pending cleared same cycle. Request during busy sets pending (one-deep, extra requests
//    merge); request on same cycle as final STORE starts next round on following cycle.
//  - Timer: free-running counter, wraps to 0 at terminal count, not reset by rounds.
//  - Per channel (order 0,4,5,6): CMD: wrt=1 for exactly 1 clk, cmd={2'b00,ch[2:0],11'h000}
//    -> WAIT_C (hold until done) -> GAP (1 clk, wrt=0) -> READ: wrt=1 1 clk, cmd=16'h0000
//    -> WAIT_R (hold until done) -> STORE: result <= rd_data[11:0], rd_data[15:12] ignored.
//    STORE -> CMD of next channel, or after ch6 -> IDLE with vld=1 for 1 clk, busy drops.
//  - cmd holds last driven value between strobes; wrt never high 2 consecutive clks.
//  - done outside WAIT_C/WAIT_R is ignored (no state change, no store).
//  - Minimum round latency, SPI done at earliest (1 clk after wrt): 4*(1+1+1+1+1+1)=24 clks
//    from CMD entry to vld.
//  - Results update only in STORE for their own channel; other results stable meanwhile.
// CONFIGURATION
//  - LD_FILT_EN defined: lft_ld/rght_ld STORE writes (old + new) >> 1, 13-bit sum, truncating;
//    first round after reset stores raw sample (internal seeded flag). steer_pot, batt raw.
//  - LD_FILT_EN undefined: all four channels store raw rd_data[11:0]; no seeded flag.
// STRUCTURE
//  - Package seg_a2d_pkg: channel localparams (CH_LFT=3'd0, CH_RGHT=3'd4, CH_STEER=3'd5,
//    CH_BATT=3'd6), sched_state_t enum {IDLE,CMD,WAIT_C,GAP,READ,WAIT_R,STORE},
//    PERIOD_W_SIM=10, PERIOD_W_REAL=18.
//  - One sub-module: a2d_period_tmr (fast_sim param, clk/rst, output tc pulse).
//  - FSM, channel index (2-bit), pending flag, result registers stay in a2d_rr_sched.
// TESTING
//  1 Reset: assert rst mid-WAIT_R of ch5 -> next clk all results 0, busy=0, wrt=0, no vld.
//  2 nxt pulse, SPI model done 1 clk after each wrt, rd_data=16'hF123/0456/0789/0ABC ->
//    cmd seq 0000,0000,2000,0000,2800,0000,3000,0000; lft_ld=123,rght_ld=456,steer=789,
//    batt=ABC; vld at 24th clk.
//  3 nxt asserted 3 times during busy -> exactly one extra round starts 1 clk after vld.
//  4 Spurious done pulses in CMD/GAP/STORE/IDLE -> no state change, no result update.
//  5 fast_sim=1, no nxt -> rounds start every 1024 clks; wrt pulses never adjacent.
//  6 LD_FILT_EN: lft samples 12'h100 then 12'h201 -> lft_ld=100 then 180; undef -> 201.

Source files
------------

// File: rtl/seg_a2d_pkg.sv
// Shared definitions for the segway A2D round-robin scheduler.
package seg_a2d_pkg;

    localparam int unsigned CMD_W         = 16;
    localparam int unsigned RES_W         = 12;
    localparam int unsigned PERIOD_W_SIM  = 10;
    localparam int unsigned PERIOD_W_REAL = 18;

    localparam logic [2:0] CH_LFT   = 3'd0;
    localparam logic [2:0] CH_RGHT  = 3'd4;
    localparam logic [2:0] CH_STEER = 3'd5;
    localparam logic [2:0] CH_BATT  = 3'd6;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WAIT_C,
        GAP,
        READ,
        WAIT_R,
        STORE
    } sched_state_t;

    // Round slot (0..3) to A2D channel number.
    function automatic logic [2:0] chan_of(input logic [1:0] idx);
        logic [2:0] ch;
        case (idx)
            2'd0:    ch = CH_LFT;
            2'd1:    ch = CH_RGHT;
            2'd2:    ch = CH_STEER;
            default: ch = CH_BATT;
        endcase
        return ch;
    endfunction

    // Conversion request word for a channel.
    function automatic logic [CMD_W-1:0] conv_cmd(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

endpackage

// File: rtl/a2d_period_tmr.sv
// Free-running round period timer; tc pulses once every 2^W clocks.
// W = 10 when fast_sim is set, otherwise 18.
module a2d_period_tmr
    import seg_a2d_pkg::*;
#(
    parameter bit fast_sim = 1'b1
)
(
    input  logic clk,
    input  logic rst,
    output logic tc
);

    localparam int unsigned TMR_W = fast_sim ? PERIOD_W_SIM : PERIOD_W_REAL;
    localparam logic [TMR_W-1:0] TC_PRE = {{(TMR_W-1){1'b1}}, 1'b0};

    logic [TMR_W-1:0] cnt;

    // Counter wraps naturally; tc is registered so it is high while cnt is all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            tc  <= 1'b0;
        end else begin
            cnt <= cnt + TMR_W'(1);
            tc  <= (cnt == TC_PRE);
        end
    end

endmodule

// File: rtl/a2d_rr_sched.sv
// Round-robin scheduler sharing one SPI master across the four segway A2D readings.
// Optional feature: define LD_FILT_EN to average new load-cell samples with the previous result.
module a2d_rr_sched
    import seg_a2d_pkg::*;
#(
    parameter bit fast_sim = 1'b1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        vld,
    output logic        busy
);

    sched_state_t     state;
    logic [1:0]       idx;
    logic             pending;
    logic [RES_W-1:0] rd_hold;
    logic             tmr_tc;
    logic             unused_rd_hi;

    assign unused_rd_hi = ^rd_data[15:12];

    a2d_period_tmr #(.fast_sim(fast_sim)) u_tmr (
        .clk (clk),
        .rst (rst),
        .tc  (tmr_tc)
    );

`ifdef LD_FILT_EN
    logic seeded;

    // Two-tap average of old and new load-cell sample, truncating.
    function automatic logic [RES_W-1:0] ld_avg(input logic [RES_W-1:0] old_v,
                                                input logic [RES_W-1:0] new_v);
        logic [RES_W:0] sum;
        sum = (RES_W+1)'(old_v) + (RES_W+1)'(new_v);
        return sum[RES_W:1];
    endfunction
`endif

    // Scheduler FSM: request merging, SPI strobes and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 2'd0;
            pending   <= 1'b0;
            rd_hold   <= '0;
            wrt       <= 1'b0;
            cmd       <= 16'h0000;
            vld       <= 1'b0;
            busy      <= 1'b0;
            lft_ld    <= 12'h000;
            rght_ld   <= 12'h000;
            steer_pot <= 12'h000;
            batt      <= 12'h000;
`ifdef LD_FILT_EN
            seeded    <= 1'b0;
`endif
        end else begin
            wrt <= 1'b0;
            vld <= 1'b0;

            // One-deep request flag; requests arriving while it is consumed merge.
            if (state == IDLE && pending) begin
                pending <= 1'b0;
            end else if (nxt || tmr_tc) begin
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pending) begin
                        state <= CMD;
                        idx   <= 2'd0;
                        busy  <= 1'b1;
                        wrt   <= 1'b1;
                        cmd   <= conv_cmd(chan_of(2'd0));
                    end
                end
                CMD: begin
                    state <= WAIT_C;
                end
                WAIT_C: begin
                    if (done) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    state <= READ;
                    wrt   <= 1'b1;
                    cmd   <= 16'h0000;
                end
                READ: begin
                    state <= WAIT_R;
                end
                WAIT_R: begin
                    if (done) begin
                        rd_hold <= rd_data[11:0];
                        state   <= STORE;
                    end
                end
                STORE: begin
                    case (idx)
`ifdef LD_FILT_EN
                        2'd0:    lft_ld  <= seeded ? ld_avg(lft_ld, rd_hold) : rd_hold;
                        2'd1:    rght_ld <= seeded ? ld_avg(rght_ld, rd_hold) : rd_hold;
`else
                        2'd0:    lft_ld  <= rd_hold;
                        2'd1:    rght_ld <= rd_hold;
`endif
                        2'd2:    steer_pot <= rd_hold;
                        default: batt      <= rd_hold;
                    endcase
                    if (idx == 2'd3) begin
                        state <= IDLE;
                        vld   <= 1'b1;
                        busy  <= 1'b0;
`ifdef LD_FILT_EN
                        seeded <= 1'b1;
`endif
                    end else begin
                        idx   <= idx + 2'd1;
                        state <= CMD;
                        wrt   <= 1'b1;
                        cmd   <= conv_cmd(chan_of(idx + 2'd1));
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_rr_sched.sv
// Self-checking bench for a2d_rr_sched (fast_sim=1); honours LD_FILT_EN when defined.
module tb_a2d_rr_sched;

    typedef struct packed {
        logic [3:0][15:0] rd;
        logic [3:0][11:0] res;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        nxt;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] steer_pot;
    logic [11:0] batt;
    logic        vld;
    logic        busy;

    always #5 clk = ~clk;

    a2d_rr_sched #(.fast_sim(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .nxt       (nxt),
        .wrt       (wrt),
        .cmd       (cmd),
        .done      (done),
        .rd_data   (rd_data),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .steer_pot (steer_pot),
        .batt      (batt),
        .vld       (vld),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wrt_total = 0;
    int stall_at = -1;
    int round_start = 0;
    int rel_cyc = 0;
    int nv = 0;
    int s_cyc = 0;
    bit got = 1'b0;
    bit vld_seen = 1'b0;
    logic resp_due = 1'b0;
    logic prev_wrt = 1'b0;
    logic spur_on = 1'b0;
    logic [15:0] resp_word = 16'h0000;
    logic [15:0] last_cmd = 16'h0000;
    logic [15:0] exp_cmd_q[$];
    logic [15:0] rd_q[$];
    logic [47:0] exp_res_q[$];
    int round_starts[$];
    logic [11:0] m_lft, m_rght, m_steer, m_batt;
    bit m_seeded;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] w0, input logic [15:0] w1,
                                input logic [15:0] w2, input logic [15:0] w3,
                                input logic [11:0] r0, input logic [11:0] r1,
                                input logic [11:0] r2, input logic [11:0] r3);
        vec_t v;
        v.rd[0] = w0; v.rd[1] = w1; v.rd[2] = w2; v.rd[3] = w3;
        v.res[0] = r0; v.res[1] = r1; v.res[2] = r2; v.res[3] = r3;
        return v;
    endfunction

    // One clock: SPI responder plus wrt/cmd monitor, sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        done    = 1'b0;
        rd_data = 16'hFBAD;
        if (resp_due) begin
            done     = 1'b1;
            rd_data  = resp_word;
            resp_due = 1'b0;
        end else if (spur_on) begin
            done = 1'b1;
        end
        if (rst) begin
            last_cmd = 16'h0000;
        end else if (wrt) begin
            chk("wrt_not_adjacent", 32'(prev_wrt), 32'd0);
            chk("busy_at_wrt", 32'(busy), 32'd1);
            checks++;
            if (exp_cmd_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_wrt: cmd %0h with no strobe expected (cycle %0d)", cmd, cyc);
            end else begin
                logic [15:0] e;
                e = exp_cmd_q.pop_front();
                if (cmd !== e) begin
                    errors++;
                    $display("FAIL cmd_seq: got %0h expected %0h (cycle %0d)", cmd, e, cyc);
                end
            end
            if (wrt_total % 8 == 0) begin
                round_start = cyc;
                round_starts.push_back(cyc);
            end
            if (wrt_total % 2 == 1) begin
                resp_word = (rd_q.size() > 0) ? rd_q.pop_front() : 16'hDEAD;
            end else begin
                resp_word = 16'hC5C5;
            end
            resp_due = (wrt_total != stall_at);
            wrt_total++;
            last_cmd = cmd;
        end else begin
            chk("cmd_hold", 32'(cmd), 32'(last_cmd));
        end
        prev_wrt = wrt;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nxt = 1'b0;
        spur_on = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        resp_due = 1'b0;
        prev_wrt = 1'b0;
        wrt_total = 0;
        stall_at = -1;
        last_cmd = 16'h0000;
        exp_cmd_q.delete();
        rd_q.delete();
        exp_res_q.delete();
        round_starts.delete();
        m_lft = 12'h000; m_rght = 12'h000; m_steer = 12'h000; m_batt = 12'h000;
        m_seeded = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic pulse_nxt();
        nxt = 1'b1;
        tick();
        nxt = 1'b0;
    endtask

    // Queue the strobes, read words and expected results for one full round.
    task automatic push_round(input vec_t v);
        exp_cmd_q.push_back(16'h0000); exp_cmd_q.push_back(16'h0000);
        exp_cmd_q.push_back(16'h2000); exp_cmd_q.push_back(16'h0000);
        exp_cmd_q.push_back(16'h2800); exp_cmd_q.push_back(16'h0000);
        exp_cmd_q.push_back(16'h3000); exp_cmd_q.push_back(16'h0000);
        for (int i = 0; i < 4; i++) rd_q.push_back(v.rd[i]);
`ifdef LD_FILT_EN
        if (m_seeded) begin
            m_lft  = 12'((13'(m_lft) + 13'(v.res[0])) >> 1);
            m_rght = 12'((13'(m_rght) + 13'(v.res[1])) >> 1);
        end else begin
            m_lft  = v.res[0];
            m_rght = v.res[1];
        end
`else
        m_lft  = v.res[0];
        m_rght = v.res[1];
`endif
        m_steer = v.res[2];
        m_batt  = v.res[3];
        m_seeded = 1'b1;
        exp_res_q.push_back({m_batt, m_steer, m_rght, m_lft});
    endtask

    task automatic wait_wrts(input int n, input int budget);
        for (int i = 0; i < budget && wrt_total < n; i++) tick();
        checks++;
        if (wrt_total < n) begin
            errors++;
            $display("FAIL wrt_timeout: saw %0d strobes, needed %0d", wrt_total, n);
        end
    endtask

    task automatic wait_vld(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (vld) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL vld_timeout: no vld within %0d clks", budget);
        end
    endtask

    task automatic check_results();
        logic [47:0] e;
        checks++;
        if (exp_res_q.size() == 0) begin
            errors++;
            $display("FAIL result_queue: vld with no expected round (cycle %0d)", cyc);
        end else begin
            e = exp_res_q.pop_front();
            chk("lft_ld", 32'(lft_ld), 32'(e[11:0]));
            chk("rght_ld", 32'(rght_ld), 32'(e[23:12]));
            chk("steer_pot", 32'(steer_pot), 32'(e[35:24]));
            chk("batt", 32'(batt), 32'(e[47:36]));
        end
    endtask

    task automatic check_round();
        check_results();
        chk("round_latency", 32'(cyc - round_start), 32'd24);
        chk("busy_at_vld", 32'(busy), 32'd0);
        tick();
        chk("vld_one_cycle", 32'(vld), 32'd0);
    endtask

    initial begin
        rst = 1'b1; nxt = 1'b0; done = 1'b0; rd_data = 16'h0000;
        m_lft = 12'h000; m_rght = 12'h000; m_steer = 12'h000; m_batt = 12'h000;
        m_seeded = 1'b0;
        vecs[0] = mk(16'hF123, 16'h0456, 16'h0789, 16'h0ABC, 12'h123, 12'h456, 12'h789, 12'hABC);
        vecs[1] = mk(16'h0FFF, 16'hFFFF, 16'h0000, 16'h8001, 12'hFFF, 12'hFFF, 12'h000, 12'h001);
        vecs[2] = mk(16'hA5A5, 16'h5A5A, 16'h1234, 16'hCDEF, 12'h5A5, 12'hA5A, 12'h234, 12'hDEF);
        vecs[3] = mk(16'h7001, 16'h3FFE, 16'hE800, 16'h0400, 12'h001, 12'hFFE, 12'h800, 12'h400);

        // Reset values, then reset while stalled in the ch5 read.
        do_reset();
        chk("rst_lft", 32'(lft_ld), 32'd0);
        chk("rst_rght", 32'(rght_ld), 32'd0);
        chk("rst_steer", 32'(steer_pot), 32'd0);
        chk("rst_batt", 32'(batt), 32'd0);
        chk("rst_wrt", 32'(wrt), 32'd0);
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_vld", 32'(vld), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        stall_at = 5;
        exp_cmd_q.push_back(16'h0000); exp_cmd_q.push_back(16'h0000);
        exp_cmd_q.push_back(16'h2000); exp_cmd_q.push_back(16'h0000);
        exp_cmd_q.push_back(16'h2800); exp_cmd_q.push_back(16'h0000);
        rd_q.push_back(16'h9111); rd_q.push_back(16'h8222); rd_q.push_back(16'h7333);
        pulse_nxt();
        wait_wrts(6, 60);
        tick();
        tick();
        chk("pre_rst_lft", 32'(lft_ld), 32'h111);
        chk("pre_rst_rght", 32'(rght_ld), 32'h222);
        chk("pre_rst_steer_untouched", 32'(steer_pot), 32'd0);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_lft", 32'(lft_ld), 32'd0);
        chk("midrst_rght", 32'(rght_ld), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_wrt", 32'(wrt), 32'd0);
        vld_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (vld) vld_seen = 1'b1;
        end
        chk("midrst_no_vld", 32'(vld_seen), 32'd0);
        chk("midrst_no_strobe", 32'(wrt_total), 32'd6);

        // Table-driven rounds.
        do_reset();
        for (int r = 0; r < 4; r++) begin
            push_round(vecs[r]);
            pulse_nxt();
            wait_vld(100, got);
            if (got) check_round();
            for (int i = 0; i < 3; i++) tick();
        end
        chk("table_cmds_consumed", 32'(exp_cmd_q.size()), 32'd0);

        // Three requests while busy (last during final STORE) give one extra round.
        do_reset();
        push_round(vecs[1]);
        push_round(vecs[2]);
        pulse_nxt();
        wait_wrts(1, 10);
        s_cyc = cyc;
        for (int k = 1; k <= 24; k++) begin
            tick();
            nxt = (k == 3 || k == 10 || k == 23);
        end
        chk("merge_vld", 32'(vld), 32'd1);
        chk("merge_latency", 32'(cyc - s_cyc), 32'd24);
        check_results();
        tick();
        chk("merge_restart_wrt", 32'(wrt), 32'd1);
        chk("merge_restart_busy", 32'(busy), 32'd1);
        wait_vld(100, got);
        if (got) check_round();
        for (int i = 0; i < 60; i++) tick();
        chk("merge_single_extra", 32'(wrt_total), 32'd16);

        // done asserted outside the wait states.
        do_reset();
        spur_on = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("spur_idle_busy", 32'(busy), 32'd0);
        chk("spur_idle_nostrobe", 32'(wrt_total), 32'd0);
        chk("spur_idle_lft", 32'(lft_ld), 32'd0);
        push_round(vecs[2]);
        pulse_nxt();
        wait_vld(100, got);
        if (got) check_round();
        for (int i = 0; i < 8; i++) tick();
        chk("spur_after_lft", 32'(lft_ld), 32'(m_lft));
        chk("spur_after_batt", 32'(batt), 32'(m_batt));
        chk("spur_after_nostrobe", 32'(wrt_total), 32'd8);
        spur_on = 1'b0;

        // Load-cell filter behaviour.
        do_reset();
        push_round(mk(16'h0100, 16'h0300, 16'h00FF, 16'h0FFF, 12'h100, 12'h300, 12'h0FF, 12'hFFF));
        pulse_nxt();
        wait_vld(100, got);
        if (got) check_round();
        chk("filt_first_lft", 32'(lft_ld), 32'h100);
        push_round(mk(16'h0201, 16'h0101, 16'h0001, 16'h0000, 12'h201, 12'h101, 12'h001, 12'h000));
        pulse_nxt();
        wait_vld(100, got);
        if (got) check_round();
`ifdef LD_FILT_EN
        chk("filt_second_lft", 32'(lft_ld), 32'h180);
        chk("filt_second_rght", 32'(rght_ld), 32'h200);
`else
        chk("filt_second_lft", 32'(lft_ld), 32'h201);
        chk("filt_second_rght", 32'(rght_ld), 32'h101);
`endif
        chk("filt_second_steer", 32'(steer_pot), 32'h001);

        // Timer-driven rounds, no nxt.
        do_reset();
        push_round(vecs[3]);
        push_round(vecs[0]);
        nv = 0;
        for (int i = 0; i < 2300; i++) begin
            tick();
            if (vld) begin
                nv++;
                check_results();
            end
        end
        chk("tmr_vld_count", 32'(nv), 32'd2);
        chk("tmr_round_count", 32'(round_starts.size()), 32'd2);
        if (round_starts.size() >= 2) begin
            chk("tmr_first_start", 32'(round_starts[0] - rel_cyc), 32'd1025);
            chk("tmr_period", 32'(round_starts[1] - round_starts[0]), 32'd1024);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
